// File: rtl/mbf_decimate_mc_pkg.sv
// mbf_decimate_mc_pkg: shared types and defaults for the multichannel decimator.
// Provides package mbf_pkg: config FSM state encoding, default widths, channel limit.
package mbf_pkg;
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_APPLY = 2'd1,
      ST_DONE  = 2'd2
   } cfg_state_t;
   localparam int MBF_DATA_WIDTH   = 24;
   localparam int MBF_CH_W         = 4;
   localparam int MBF_DCEF_W       = 16;
   localparam int MBF_MAX_CHANNELS = 16;
   localparam int MBF_DCEF_DEFAULT = 2;
endpackage

// File: rtl/mbf_decimate_mc_if.sv
// mbf_decimate_mc_if: config handshake, TDM sample stream and error bus of the decimator.
// Ports: none (signals only). Modports: master drives cfg_*/din*/err_clr and observes the
// rest; slave (the decimator) receives cfg_*/din*/err_clr and drives cfg_ready/cfg_done,
// dout/dout_valid/dout_ch and err_ch.
interface mbf_decimate_mc_if
   import mbf_pkg::*;
#(
   parameter int DATA_WIDTH = MBF_DATA_WIDTH,
   parameter int CH_W       = MBF_CH_W,
   parameter int DCEF_W     = MBF_DCEF_W
) ();
   logic                  cfg_valid;
   logic                  cfg_ready;
   logic                  cfg_bcast;
   logic [CH_W-1:0]       cfg_ch;
   logic [DCEF_W-1:0]     cfg_dcef;
   logic                  cfg_done;
   logic [DATA_WIDTH-1:0] din;
   logic                  din_valid;
   logic [CH_W-1:0]       din_ch;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic [CH_W-1:0]       dout_ch;
   logic                  err_ch;
   logic                  err_clr;

   modport master (
      output cfg_valid, cfg_bcast, cfg_ch, cfg_dcef, din, din_valid, din_ch, err_clr,
      input  cfg_ready, cfg_done, dout, dout_valid, dout_ch, err_ch
   );
   modport slave (
      input  cfg_valid, cfg_bcast, cfg_ch, cfg_dcef, din, din_valid, din_ch, err_clr,
      output cfg_ready, cfg_done, dout, dout_valid, dout_ch, err_ch
   );
endinterface

// File: rtl/mbf_decimate_mc_cfg_fsm.sv
// mbf_decim_cfg_fsm: config handshake RUN -> APPLY -> DONE for the decimation table.
// Ports: CLK, nRST (async, active-low); i_cfg_valid/o_cfg_ready handshake with
// i_cfg_bcast, i_cfg_ch, i_cfg_dcef request; o_cfg_done pulse; table write controls
// o_wr_en/o_wr_bcast/o_wr_ch/o_wr_dcef (valid in APPLY); o_cfg_err pulse in APPLY for
// an out-of-range unicast channel.
module mbf_decim_cfg_fsm
   import mbf_pkg::*;
#(
   parameter int NUM_CH = MBF_MAX_CHANNELS,
   parameter int CH_W   = MBF_CH_W,
   parameter int DCEF_W = MBF_DCEF_W
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              i_cfg_valid,
   input  logic              i_cfg_bcast,
   input  logic [CH_W-1:0]   i_cfg_ch,
   input  logic [DCEF_W-1:0] i_cfg_dcef,
   output logic              o_cfg_ready,
   output logic              o_cfg_done,
   output logic              o_wr_en,
   output logic              o_wr_bcast,
   output logic [CH_W-1:0]   o_wr_ch,
   output logic [DCEF_W-1:0] o_wr_dcef,
   output logic              o_cfg_err
);
   // one extra bit so NUM_CH == 2^CH_W is representable
   localparam logic [CH_W:0] LP_NUM_CH = (CH_W+1)'(NUM_CH);

   cfg_state_t        r_state;
   logic              r_ready;
   logic              r_done;
   logic              r_wr_en;
   logic              r_bcast;
   logic [CH_W-1:0]   r_ch;
   logic [DCEF_W-1:0] r_dcef;
   logic              r_err;
   logic              w_ch_ok;

   assign w_ch_ok = {1'b0, i_cfg_ch} < LP_NUM_CH;

   // write enable and error are set on acceptance so they are live during APPLY
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= ST_RUN;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
         r_wr_en <= 1'b0;
         r_bcast <= 1'b0;
         r_ch    <= '0;
         r_dcef  <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (i_cfg_valid) begin
                  r_bcast <= i_cfg_bcast;
                  r_ch    <= i_cfg_ch;
                  r_dcef  <= i_cfg_dcef;
                  r_wr_en <= i_cfg_bcast || w_ch_ok;
                  r_err   <= !i_cfg_bcast && !w_ch_ok;
                  r_ready <= 1'b0;
                  r_state <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               r_wr_en <= 1'b0;
               r_err   <= 1'b0;
               r_done  <= 1'b1;
               r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= ST_RUN;
            end
            default: begin
               r_wr_en <= 1'b0;
               r_err   <= 1'b0;
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= ST_RUN;
            end
         endcase
      end
   end

   assign o_cfg_ready = r_ready;
   assign o_cfg_done  = r_done;
   assign o_wr_en     = r_wr_en;
   assign o_wr_bcast  = r_bcast;
   assign o_wr_ch     = r_ch;
   assign o_wr_dcef   = r_dcef;
   assign o_cfg_err   = r_err;
endmodule

// File: rtl/mbf_decimate_mc.sv
// mbf_decimate_mc: multichannel TDM decimator keeping one sample in every dcef[ch] per channel.
// Ports: CLK, nRST (async, active-low); bus (mbf_decimate_mc_if.slave) carrying the config
// handshake (cfg_valid/cfg_ready/cfg_bcast/cfg_ch/cfg_dcef/cfg_done), the input stream
// (din/din_valid/din_ch), the registered output (dout/dout_valid/dout_ch) and the sticky
// channel error (err_ch/err_clr).
module mbf_decimate_mc
   import mbf_pkg::*;
#(
   parameter int DATA_WIDTH   = MBF_DATA_WIDTH,
   parameter int NUM_CH       = MBF_MAX_CHANNELS,
   parameter int CH_W         = MBF_CH_W,
   parameter int DCEF_W       = MBF_DCEF_W,
   parameter int DCEF_DEFAULT = MBF_DCEF_DEFAULT
) (
   input logic                CLK,
   input logic                nRST,
   mbf_decimate_mc_if.slave   bus
);
   localparam logic [CH_W:0] LP_NUM_CH = (CH_W+1)'(NUM_CH);

   logic [DCEF_W-1:0]     r_dcef [NUM_CH];
   logic [DCEF_W-1:0]     r_cnt  [NUM_CH];
   logic [DATA_WIDTH-1:0] r_dout;
   logic [CH_W-1:0]       r_dout_ch;
   logic                  r_dout_valid;
   logic                  r_err;

   logic                  w_wr_en;
   logic                  w_wr_bcast;
   logic [CH_W-1:0]       w_wr_ch;
   logic [DCEF_W-1:0]     w_wr_dcef;
   logic                  w_cfg_err;
   logic                  w_ch_ok;
   logic                  w_in_ok;
   logic                  w_in_bad;
   logic [CH_W-1:0]       w_idx;
   logic [DCEF_W-1:0]     w_dcef;
   logic [DCEF_W-1:0]     w_cnt;
   logic [DCEF_W:0]       w_eff;
   logic [DCEF_W:0]       w_inc;
   logic [DCEF_W-1:0]     w_nxt;
   logic                  w_keep;

   mbf_decim_cfg_fsm #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W),
      .DCEF_W (DCEF_W)
   ) u_cfg (
      .CLK         (CLK),
      .nRST        (nRST),
      .i_cfg_valid (bus.cfg_valid),
      .i_cfg_bcast (bus.cfg_bcast),
      .i_cfg_ch    (bus.cfg_ch),
      .i_cfg_dcef  (bus.cfg_dcef),
      .o_cfg_ready (bus.cfg_ready),
      .o_cfg_done  (bus.cfg_done),
      .o_wr_en     (w_wr_en),
      .o_wr_bcast  (w_wr_bcast),
      .o_wr_ch     (w_wr_ch),
      .o_wr_dcef   (w_wr_dcef),
      .o_cfg_err   (w_cfg_err)
   );

   assign w_ch_ok  = {1'b0, bus.din_ch} < LP_NUM_CH;
   assign w_in_ok  = bus.din_valid && w_ch_ok;
   assign w_in_bad = bus.din_valid && !w_ch_ok;
   // table is only addressed by a range-checked channel
   assign w_idx    = w_in_ok ? bus.din_ch : '0;
   assign w_dcef   = r_dcef[w_idx];
   assign w_cnt    = r_cnt[w_idx];
   // factor 0 behaves as 1; extra bit keeps cnt+1 from wrapping at the maximum factor
   assign w_eff    = (w_dcef == '0) ? (DCEF_W+1)'(1) : {1'b0, w_dcef};
   assign w_inc    = {1'b0, w_cnt} + (DCEF_W+1)'(1);
   assign w_nxt    = (w_inc >= w_eff) ? '0 : w_inc[DCEF_W-1:0];
   assign w_keep   = w_in_ok && (w_cnt == '0);

   // a config write clears the counter and takes priority over the datapath increment
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_dcef[c] <= DCEF_W'(DCEF_DEFAULT);
            r_cnt[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_wr_en && (w_wr_bcast || w_wr_ch == CH_W'(c))) begin
               r_dcef[c] <= w_wr_dcef;
               r_cnt[c]  <= '0;
            end else if (w_in_ok && bus.din_ch == CH_W'(c)) begin
               r_cnt[c]  <= w_nxt;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_dout       <= '0;
         r_dout_ch    <= '0;
         r_dout_valid <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_dout_valid <= w_keep;
         if (w_keep) begin
            r_dout    <= bus.din;
            r_dout_ch <= bus.din_ch;
         end
         // a new error wins over a simultaneous clear
         r_err <= (w_in_bad || w_cfg_err) ? 1'b1 : (bus.err_clr ? 1'b0 : r_err);
      end
   end

   assign bus.dout       = r_dout;
   assign bus.dout_ch    = r_dout_ch;
   assign bus.dout_valid = r_dout_valid;
   assign bus.err_ch     = r_err;
endmodule

// File: tb/tb_mbf_decimate_mc.sv
// tb_mbf_decimate_mc: randomized scoreboard bench for the multichannel decimator (12 channels).
module tb_mbf_decimate_mc;
   localparam int NCH = 12;

   typedef struct {
      logic [23:0] d;
      logic [3:0]  ch;
      int          cyc;
   } exp_t;

   logic CLK = 1'b0;
   logic nRST = 1'b0;
   always #5 CLK = ~CLK;

   mbf_decimate_mc_if #(.DATA_WIDTH(24), .CH_W(4), .DCEF_W(16)) bus ();

   mbf_decimate_mc #(
      .DATA_WIDTH   (24),
      .NUM_CH       (NCH),
      .CH_W         (4),
      .DCEF_W       (16),
      .DCEF_DEFAULT (2)
   ) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   exp_t q[$];
   int   m_dcef [NCH];
   int   m_cnt  [NCH];
   bit   m_err;
   int   m_busy;
   bit   m_bc;
   int   m_ch;
   int   m_dv;
   int   cyc;
   int   checks;
   int   failures;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // reference model: per-channel keep-one-in-N counters and a 3-cycle config occupancy
   initial begin : model
      bit set;
      int e;
      int c;
      forever begin
         @(posedge CLK or negedge nRST);
         if (!nRST) begin
            for (int k = 0; k < NCH; k++) begin
               m_dcef[k] = 2;
               m_cnt[k]  = 0;
            end
            m_err  = 0;
            m_busy = 0;
            q.delete();
         end else begin
            set = 0;
            cyc++;
            if (bus.din_valid) begin
               c = int'(bus.din_ch);
               if (c < NCH) begin
                  e = (m_dcef[c] == 0) ? 1 : m_dcef[c];
                  if (m_cnt[c] == 0) q.push_back('{bus.din, bus.din_ch, cyc});
                  m_cnt[c] = (m_cnt[c] + 1) % e;
               end else set = 1;
            end
            if (m_busy == 2) begin
               if (m_bc) begin
                  for (int k = 0; k < NCH; k++) begin
                     m_dcef[k] = m_dv;
                     m_cnt[k]  = 0;
                  end
               end else if (m_ch < NCH) begin
                  m_dcef[m_ch] = m_dv;
                  m_cnt[m_ch]  = 0;
               end else set = 1;
               m_busy = 1;
            end else if (m_busy == 1) begin
               m_busy = 0;
            end else if (bus.cfg_valid) begin
               m_bc   = bus.cfg_bcast;
               m_ch   = int'(bus.cfg_ch);
               m_dv   = int'(bus.cfg_dcef);
               m_busy = 2;
            end
            m_err = set ? 1'b1 : (bus.err_clr ? 1'b0 : m_err);
         end
      end
   end

   initial begin : monitor
      bit   due;
      exp_t e;
      forever begin
         @(negedge CLK);
         if (nRST) begin
            due = q.size() > 0 && q[0].cyc == cyc;
            if (due || bus.dout_valid) begin
               chk("dout_valid", 32'(bus.dout_valid), 32'(due));
               if (due) begin
                  e = q.pop_front();
                  if (bus.dout_valid) begin
                     chk("dout", 32'(bus.dout), 32'(e.d));
                     chk("dout_ch", 32'(bus.dout_ch), 32'(e.ch));
                  end
               end
            end
            chk("cfg_ready", 32'(bus.cfg_ready), 32'(m_busy == 0));
            chk("cfg_done", 32'(bus.cfg_done), 32'(m_busy == 1));
            chk("err_ch", 32'(bus.err_ch), 32'(m_err));
         end
      end
   end

   task automatic step(input bit v, input logic [3:0] ch, input logic [23:0] d, input bit clr);
      if (m_busy != 0) bus.cfg_valid = 1'b0;
      bus.din_valid = v;
      bus.din_ch    = ch;
      bus.din       = d;
      bus.err_clr   = clr;
      @(negedge CLK);
   endtask

   task automatic cfg_req(input bit bc, input logic [3:0] ch, input logic [15:0] dv);
      bus.cfg_valid = 1'b1;
      bus.cfg_bcast = bc;
      bus.cfg_ch    = ch;
      bus.cfg_dcef  = dv;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 10 && (bus.cfg_valid || m_busy != 0); i++) step(1'b0, 4'd0, 24'd0, 1'b0);
      chk("cfg_idle", 32'(bus.cfg_valid || m_busy != 0), 32'd0);
   endtask

   task automatic chk_reset();
      chk("rst_dout", 32'(bus.dout), 32'd0);
      chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
      chk("rst_dout_ch", 32'(bus.dout_ch), 32'd0);
      chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
      chk("rst_cfg_done", 32'(bus.cfg_done), 32'd0);
      chk("rst_err_ch", 32'(bus.err_ch), 32'd0);
   endtask

   task automatic rr(input int rounds, input int base);
      for (int n = 0; n < rounds; n++)
         for (int c = 0; c < 4; c++) step(1'b1, 4'(c), {4'(c), 20'(base + n)}, 1'b0);
   endtask

   initial begin
      logic [15:0] dv;
      logic [3:0]  ch;
      bus.cfg_valid = 1'b0;
      bus.cfg_bcast = 1'b0;
      bus.cfg_ch    = '0;
      bus.cfg_dcef  = '0;
      bus.din       = '0;
      bus.din_valid = 1'b0;
      bus.din_ch    = '0;
      bus.err_clr   = 1'b0;
      repeat (3) @(negedge CLK);
      chk_reset();
      nRST = 1'b1;
      rr(8, 0);
      cfg_req(1'b0, 4'd2, 16'd5);
      rr(15, 100);
      wait_idle();
      cfg_req(1'b1, 4'd0, 16'd0);
      rr(6, 200);
      wait_idle();
      cfg_req(1'b1, 4'd0, 16'd1);
      rr(6, 300);
      wait_idle();
      step(1'b1, 4'd15, 24'hBAD, 1'b0);
      step(1'b0, 4'd0, 24'd0, 1'b0);
      step(1'b0, 4'd0, 24'd0, 1'b1);
      step(1'b0, 4'd0, 24'd0, 1'b0);
      step(1'b1, 4'd15, 24'hBAD, 1'b1);
      step(1'b0, 4'd0, 24'd0, 1'b1);
      cfg_req(1'b0, 4'd13, 16'd4);
      wait_idle();
      step(1'b0, 4'd0, 24'd0, 1'b1);
      cfg_req(1'b0, 4'd0, 16'd3);
      wait_idle();
      step(1'b1, 4'd0, 24'h000A01, 1'b0);
      cfg_req(1'b0, 4'd0, 16'd4);
      for (int n = 0; n < 10; n++) step(1'b1, 4'd0, 24'(24'h000B00 + n), 1'b0);
      wait_idle();
      cfg_req(1'b1, 4'd0, 16'd3);
      wait_idle();
      cfg_req(1'b1, 4'd0, 16'd7);
      step(1'b1, 4'd1, 24'h000C00, 1'b0);
      #2;
      nRST = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.din_valid = 1'b0;
      #1;
      chk_reset();
      @(negedge CLK);
      @(negedge CLK);
      chk_reset();
      #2;
      nRST = 1'b1;
      for (int n = 0; n < 6; n++) step(1'b1, 4'd1, 24'(24'h000D00 + n), 1'b0);
      for (int i = 0; i < 600; i++) begin
         if (!bus.cfg_valid && m_busy == 0 && $urandom_range(0, 24) == 0) begin
            dv = ($urandom_range(0, 7) == 7) ? 16'hFFFF : 16'($urandom_range(0, 6));
            cfg_req($urandom_range(0, 3) == 0, 4'($urandom_range(0, 13)), dv);
         end
         ch = ($urandom_range(0, 29) == 0) ? 4'(12 + $urandom_range(0, 3)) : 4'($urandom_range(0, 11));
         step($urandom_range(0, 3) != 0, ch, 24'($urandom), $urandom_range(0, 15) == 0);
      end
      wait_idle();
      repeat (3) step(1'b0, 4'd0, 24'd0, 1'b0);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mbf_decimate_mc.md
Name: mbf_decimate_mc

Overview:
- Parametrised, fully synchronous multichannel decimator for the DDC/MHBF chain.
- Sits after the multichannel half-band/CIC stages.
- Accepts a TDM sample stream tagged with a channel index and keeps one sample in every DCEF[ch] samples of each channel.
- Decimation factor is programmable per channel or by broadcast, through a valid/ready config handshake.
- Output is registered, with a one-cycle valid pulse and a channel tag.

Parameters:
- DATA_WIDTH, 24, sample width (two's complement, passed unmodified).
- NUM_CH, 16, channel count (1..2^CH_W).
- CH_W, 4, channel index width.
- DCEF_W, 16, decimation factor and per-channel counter width.
- DCEF_DEFAULT, 2, factor loaded into every channel at reset.

Ports:
- CLK, in, 1: clock.
- nRST, in, 1: reset, asynchronous, active-low.
- cfg_valid, in, 1: config request.
- cfg_ready, out, 1: config accepted when cfg_valid & cfg_ready.
- cfg_bcast, in, 1: 1 = write the factor to all channels.
- cfg_ch, in, CH_W: target channel (ignored if cfg_bcast = 1).
- cfg_dcef, in, DCEF_W: new decimation factor.
- cfg_done, out, 1: one-cycle pulse when the config has been applied.
- din, in, DATA_WIDTH: input sample.
- din_valid, in, 1: input sample qualifier; any duty cycle, including back-to-back.
- din_ch, in, CH_W: channel of din.
- dout, out, DATA_WIDTH: kept sample.
- dout_valid, out, 1: one-cycle pulse per kept sample.
- dout_ch, out, CH_W: channel of dout.
- err_ch, out, 1: sticky flag for an out-of-range channel on din_ch or cfg_ch.
- err_clr, in, 1: clears err_ch.

Behaviour:
- Reset values:
  - dout = 0, dout_valid = 0, dout_ch = 0.
  - cfg_done = 0, cfg_ready = 1, err_ch = 0.
  - All cnt[ch] = 0; all dcef[ch] = DCEF_DEFAULT; FSM = RUN.
  - Reset mid-stream or mid-config aborts immediately.
- Effective factor: eff = (dcef[ch] == 0) ? 1 : dcef[ch]. A factor of 0 or 1 gives pass-through.
- Datapath, on each cycle with din_valid = 1 and din_ch < NUM_CH:
  - If cnt[din_ch] == 0, the sample is kept: next cycle dout = din, dout_ch = din_ch, dout_valid = 1.
  - Latency is exactly 1 cycle.
  - cnt[din_ch] <= (cnt + 1 >= eff) ? 0 : cnt + 1.
  - The first sample of every channel after reset or reconfig is kept.
- Hold and channel independence:
  - dout and dout_ch hold their values between pulses.
  - dout_valid is low on any cycle with no kept sample.
  - Channels are independent; interleave order is arbitrary.
  - The same channel on consecutive cycles is legal.
- Out-of-range channel (din_ch >= NUM_CH): sample dropped, no counter change, err_ch set.
- err_ch is sticky until err_clr. If err_clr and a new error occur in the same cycle, the set wins.
- Config FSM:
  - RUN: cfg_ready = 1. On cfg_valid, latch bcast/ch/dcef and go to APPLY.
  - APPLY: cfg_ready = 0. Write dcef and clear cnt for the target channel (all channels if bcast); go to DONE.
  - DONE: cfg_ready = 0, cfg_done = 1 for exactly one cycle; go to RUN.
  - Each accepted request occupies 3 cycles; the next acceptance is possible on the cycle after DONE.
- Config with out-of-range cfg_ch (no bcast): accepted, table untouched, err_ch set, cfg_done still pulses.
- Datapath never stalls during config:
  - Samples arriving in the APPLY cycle use the old dcef/cnt.
  - The config clear of cnt wins over the datapath increment, so the next sample of that channel is kept with the new factor.
- Counter width DCEF_W: cnt never exceeds eff-1. No wrap beyond eff, including eff = 2^DCEF_W - 1.
- Storage is register arrays of NUM_CH entries for dcef and cnt. Indexing is with din_ch only after the range check, so there is no X on out-of-range indices.

Decomposition:
- Shared package mbf_pkg:
  - Config FSM state encodings RUN/APPLY/DONE.
  - Defaults: DATA_WIDTH 24, CH_W 4, DCEF_W 16.
  - Constant MBF_MAX_CHANNELS = 16.
- Natural sub-module: mbf_decim_cfg_fsm, which holds the handshake, latched request and cfg_done, and produces write-enable, write-channel, bcast and dcef for the table.
- The table, counters and datapath stay in the top level.

Test Plan:
- Reset, then 4 channels round-robin back-to-back, din = {ch, n}, default DCEF = 2 → every channel keeps samples n = 0, 2, 4…; each dout_valid is 1 cycle after the kept input; dout_ch matches.
- cfg ch2 = 5 while streaming → cfg_ready low 2 cycles, cfg_done pulses once. Ch2 keeps the next sample, then every 5th; other channels stay at 1 in 2.
- Broadcast cfg_dcef = 0, then 1 → pass-through on all channels; dout_valid on every input cycle.
- din_ch = 15 with NUM_CH = 12 → no dout_valid, err_ch = 1 and held. err_clr → err_ch = 0. Simultaneous err_clr and bad channel → err_ch stays 1.
- Ch0 sample arriving in the APPLY cycle of a ch0 reconfig → the old factor decides keep/drop, and the next ch0 sample is kept.
- nRST asserted mid-APPLY → all outputs return to reset values; dcef = DCEF_DEFAULT on all channels; the first sample after release is kept.
